// File: rtl/alu_exec_pkg.sv
// Shared opcode values, FSM state encoding and decoded-control record for the
// ALU execute-stage controller. SLT legality is selected by ALU_EXEC_SLT_EN.
package alu_exec_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic op1;
    logic op2;
    logic sub;
    logic cin;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Request and result handshake bundle of the ALU execute-stage controller.
// The controller is the slave; the issuing/consuming logic is the master.
interface alu_exec_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             carry_flag;
  logic             err;

  modport master (
    output in_valid, opcode, a_in, b_in, out_ready,
    input  in_ready, out_valid, result, zero_flag, carry_flag, err
  );

  modport slave (
    input  in_valid, opcode, a_in, b_in, out_ready,
    output in_ready, out_valid, result, zero_flag, carry_flag, err
  );
endinterface

// File: rtl/alu_exec_decode.sv
// Combinational opcode decoder producing single-bit ALU controls.
// Opcode 111 (SLT) is legal only when ALU_EXEC_SLT_EN is defined.
module alu_exec_decode
  import alu_exec_pkg::*;
(
  input  logic [2:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '{op1: 1'b0, op2: 1'b0, sub: 1'b0, cin: 1'b0, illegal: 1'b0};
    case (opcode)
      OP_AND: ctrl = '{op1: 1'b0, op2: 1'b0, sub: 1'b0, cin: 1'b0, illegal: 1'b0};
      OP_OR:  ctrl = '{op1: 1'b0, op2: 1'b1, sub: 1'b0, cin: 1'b0, illegal: 1'b0};
      OP_ADD: ctrl = '{op1: 1'b1, op2: 1'b0, sub: 1'b0, cin: 1'b0, illegal: 1'b0};
      OP_SUB: ctrl = '{op1: 1'b1, op2: 1'b0, sub: 1'b1, cin: 1'b1, illegal: 1'b0};
`ifdef ALU_EXEC_SLT_EN
      OP_SLT: ctrl = '{op1: 1'b1, op2: 1'b1, sub: 1'b1, cin: 1'b1, illegal: 1'b0};
`endif
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: latches a request, holds the ripple ALU inputs for
// SETTLE_CYCLES, captures result/flags and offers them downstream. See ALU_EXEC_SLT_EN.
module alu_exec_ctrl
  import alu_exec_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_ctrl_if.slave   io,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [WIDTH-1:0] alu_sub,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_cout
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  ctrl_t      dec;

  alu_exec_decode u_decode (
    .opcode (io.opcode),
    .ctrl   (dec)
  );

  // in_ready/out_valid are registered alongside the state so they are pure state decodes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      io.in_ready   <= 1'b1;
      io.out_valid  <= 1'b0;
      io.result     <= '0;
      io.zero_flag  <= 1'b0;
      io.carry_flag <= 1'b0;
      io.err        <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_cin       <= 1'b0;
      alu_op1       <= '0;
      alu_op2       <= '0;
      alu_sub       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.in_valid) begin
            io.in_ready <= 1'b0;
            if (dec.illegal) begin
              // Illegal opcodes bypass the ALU entirely; its inputs keep their last values.
              state         <= ST_DONE;
              io.out_valid  <= 1'b1;
              io.result     <= '0;
              io.zero_flag  <= 1'b0;
              io.carry_flag <= 1'b0;
              io.err        <= 1'b1;
            end else begin
              state   <= ST_SETTLE;
              cnt     <= CNT_LOAD;
              alu_a   <= io.a_in;
              alu_b   <= io.b_in;
              alu_cin <= dec.cin;
              alu_op1 <= {WIDTH{dec.op1}};
              alu_op2 <= {WIDTH{dec.op2}};
              alu_sub <= {WIDTH{dec.sub}};
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == 4'd0) begin
            state         <= ST_DONE;
            io.out_valid  <= 1'b1;
            io.result     <= alu_out;
            io.zero_flag  <= alu_zero;
            io.carry_flag <= alu_cout;
            io.err        <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (io.out_ready) begin
            state        <= ST_IDLE;
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          io.out_valid <= 1'b0;
          io.in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage controller sitting directly upstream of the 32-bit ripple ALU (`thirty_two_alu`). It accepts an opcode and two operands over a valid/ready handshake, decodes the opcode into the ALU's replicated per-bit `op1`/`op2`/`sub` vectors and carry-in, and holds them stable for a programmable ripple-settle window. It then registers `out`, `zero` and `cout` and presents them downstream over a second valid/ready handshake.

## Interface
- `WIDTH`, 32, datapath width; must match the ALU.
- `SETTLE_CYCLES`, 2, cycles the ALU inputs are held before capture; legal range 1..15.

- `clk` input 1 — sole clock, rising edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `in_valid` input 1 — request present.
- `in_ready` output 1 — controller can accept a request.
- `opcode` input 3 — operation select.
- `a_in`, `b_in` input WIDTH — operands.
- `alu_a`, `alu_b` output WIDTH — operands to the ALU.
- `alu_cin` output 1 — ALU carry-in.
- `alu_op1`, `alu_op2`, `alu_sub` output WIDTH — ALU controls, each bit a replica of the decoded control bit.
- `alu_out` input WIDTH — ALU result.
- `alu_zero`, `alu_cout` input 1 — ALU flags.
- `out_valid` output 1 — result present.
- `out_ready` input 1 — consumer accepts the result.
- `result` output WIDTH — registered result.
- `zero_flag`, `carry_flag`, `err` output 1 — registered flags; `err` marks an illegal opcode.

## Operation
- Opcode decode, given as (op1, op2, sub, cin):
  - `000` AND → (0,0,0,0)
  - `001` OR → (0,1,0,0)
  - `010` ADD → (1,0,0,0)
  - `110` SUB → (1,0,1,1)
  - `111` SLT → (1,1,1,1)
  - `011`, `100`, `101` are illegal.
- FSM states IDLE, SETTLE, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, latch `a_in`/`b_in` into `alu_a`/`alu_b`, latch the decoded controls, and load the settle counter with SETTLE_CYCLES−1.
  - A legal opcode moves to SETTLE. An illegal opcode moves straight to DONE with `result`=0, both flags 0, `err`=1, and the ALU outputs unchanged.
- SETTLE:
  - `in_ready` = 0; the counter decrements each cycle.
  - On the cycle the counter reads 0, capture `alu_out` → `result`, `alu_zero` → `zero_flag`, `alu_cout` → `carry_flag`, clear `err`, and move to DONE.
- DONE:
  - `out_valid` = 1; `result` and flags are held stable.
  - When `out_ready`=1, move to IDLE. `in_ready` stays 0 in DONE, so accept and complete never overlap.
- ALU drive signals hold their last value outside an accept; the ALU is never driven from live `a_in`/`b_in`.
- Reset (`rst_n`=0 at a rising edge):
  - State → IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `result`, `alu_a`, `alu_b`, `alu_op1`, `alu_op2`, `alu_sub` = 0.
  - `alu_cin`, `zero_flag`, `carry_flag`, `err` = 0.
  - An operation in flight is dropped with no output.

## Timing
- Accept edge = cycle 0.
- The ALU sees new inputs from cycle 0+.
- `out_valid` rises after the edge at cycle SETTLE_CYCLES, so latency is SETTLE_CYCLES+1 cycles from accept to first valid.
- Illegal opcode: `out_valid` is asserted one cycle after accept.
- Throughput: one request per SETTLE_CYCLES+2 cycles with `out_ready` held at 1.
- `in_ready` and `out_valid` are Moore outputs, decoded from state only.
- Handshake fires on valid & ready at a rising edge.

## Configuration
- `ALU_EXEC_SLT_EN` defined: opcode `111` is legal SLT as decoded above.
- `ALU_EXEC_SLT_EN` undefined: `111` is illegal and treated exactly like `011`.

## Structure
- Package `alu_exec_pkg`: opcode localparams (`OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_SLT`) and FSM state encoding.
- Sub-module `alu_exec_decode`: combinational decoder, opcode → {op1, op2, sub, cin, illegal}.
  - Honours `ALU_EXEC_SLT_EN`.
  - Replication to WIDTH is done in the parent.

## Test plan
- ADD a=40, b=10, `out_ready`=1 → `result`=50, `zero_flag`=0, `out_valid` at cycle 3 (SETTLE_CYCLES=2); `alu_op1` = all-ones, `alu_op2`=0.
- SUB a=40, b=10 → 30 with `alu_cin`=1 and `alu_sub`=0xFFFFFFFF. Then SUB a=10, b=10 → `result`=0, `zero_flag`=1.
- AND a=60, b=30 → 28. OR a=60, b=30 → 62. Check throughput of one result per 4 cycles.
- Opcode `011` → `out_valid` at cycle 1, `result`=0, `err`=1. Without `ALU_EXEC_SLT_EN`, opcode `111` gives the same response.
- `out_ready` held 0 for 5 cycles in DONE → `result` and flags stable, `in_ready`=0, a new `in_valid` is ignored. On release, a single handshake fires, then IDLE.
- `rst_n` low during SETTLE → next cycle IDLE, `out_valid`=0, all outputs at reset values, no stale result after reset.
